// File: rtl/fault_sensor_array.sv
// Multi-lane complementary shadow-register fault sensor with sticky status,
// a saturating fault counter, lockdown, and a fault-injection self-test path.
module fault_sensor_array #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [WIDTH*LANES-1:0] data,
    input  logic [LANES-1:0]       lane_en,
    input  logic [LANES-1:0]       inj_mask,
    input  logic                   status_clr,
    output logic [WIDTH*LANES-1:0] q,
    output logic                   alarm,
    output logic [LANES-1:0]       alarm_vec,
    output logic [LANES-1:0]       status,
    output logic [CNT_W-1:0]       fault_cnt,
    output logic                   lockdown,
    output logic                   selftest_ok
);

    localparam logic [CNT_W:0] THRESH_CMP = (CNT_W+1)'(THRESH);
    localparam bit             LOCK_EN    = (THRESH != 0);

    logic [WIDTH*LANES-1:0] main_reg;
    logic [WIDTH*LANES-1:0] shadow_reg;
    logic [LANES-1:0]       inj_flag;
    logic [LANES-1:0]       raw;
    logic [LANES-1:0]       qa;
    logic [LANES-1:0]       th;

    // Injected lanes deliberately store a non-complementary shadow copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg   <= '0;
            shadow_reg <= '1;
            inj_flag   <= '0;
        end else if (load) begin
            main_reg <= data;
            inj_flag <= inj_mask;
            for (int i = 0; i < LANES; i++) begin
                shadow_reg[i*WIDTH +: WIDTH] <= inj_mask[i] ? data[i*WIDTH +: WIDTH]
                                                            : ~data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < LANES; i++) begin
            raw[i] = |(~(main_reg[i*WIDTH +: WIDTH] ^ shadow_reg[i*WIDTH +: WIDTH]));
        end
    end

    assign qa = raw & lane_en & ~inj_flag;
    assign th = raw & inj_flag;
    assign q  = main_reg;

    // A new alert outranks a simultaneous status clear; counter and lockdown ignore the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm       <= 1'b0;
            alarm_vec   <= '0;
            status      <= '0;
            fault_cnt   <= '0;
            lockdown    <= 1'b0;
            selftest_ok <= 1'b0;
        end else begin
            alarm_vec   <= qa;
            alarm       <= |qa;
            selftest_ok <= |th;
            status      <= (status & ~{LANES{status_clr}}) | qa;
            if (|qa && fault_cnt != {CNT_W{1'b1}}) begin
                fault_cnt <= fault_cnt + CNT_W'(1);
            end
            if (LOCK_EN && {1'b0, fault_cnt} >= THRESH_CMP) begin
                lockdown <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fault_sensor_array.sv
// Randomised and directed bench for fault_sensor_array, checked against a
// lane-level behavioural model; faults are planted by forcing the shadow register.
module tb_fault_sensor_array;

    localparam int WIDTH   = 8;
    localparam int LANES   = 4;
    localparam int CNT_W   = 8;
    localparam int THRESH  = 4;
    localparam int DW      = WIDTH * LANES;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LMASK   = (1 << WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load;
    logic [DW-1:0]        data;
    logic [LANES-1:0]     lane_en;
    logic [LANES-1:0]     inj_mask;
    logic                 status_clr;
    logic [DW-1:0]        q;
    logic                 alarm;
    logic [LANES-1:0]     alarm_vec;
    logic [LANES-1:0]     status;
    logic [CNT_W-1:0]     fault_cnt;
    logic                 lockdown;
    logic                 selftest_ok;

    int                   m_main   [LANES];
    int                   m_shadow [LANES];
    bit                   m_inj    [LANES];
    logic [LANES-1:0]     e_alarm_vec;
    logic [LANES-1:0]     e_status;
    logic                 e_alarm;
    logic                 e_selftest;
    logic                 e_lock;
    int                   e_cnt;
    logic [DW-1:0]        force_val;
    int                   checks = 0;
    int                   fails  = 0;

    always #5 clk = ~clk;

    fault_sensor_array #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .CNT_W (CNT_W),
        .THRESH(THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .lane_en    (lane_en),
        .inj_mask   (inj_mask),
        .status_clr (status_clr),
        .q          (q),
        .alarm      (alarm),
        .alarm_vec  (alarm_vec),
        .status     (status),
        .fault_cnt  (fault_cnt),
        .lockdown   (lockdown),
        .selftest_ok(selftest_ok)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // A lane alerts when at least one main/shadow bit pair agrees.
    function automatic bit laneRaw(input int i);
        int same = 0;
        for (int b = 0; b < WIDTH; b++) begin
            if (m_main[i][b] == m_shadow[i][b]) same++;
        end
        return same > 0;
    endfunction

    function automatic logic [DW-1:0] packShadow();
        logic [DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'(m_shadow[i]);
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < LANES; i++) begin
            m_main[i]   = 0;
            m_shadow[i] = LMASK;
            m_inj[i]    = 1'b0;
        end
        e_alarm_vec = '0;
        e_status    = '0;
        e_alarm     = 1'b0;
        e_selftest  = 1'b0;
        e_lock      = 1'b0;
        e_cnt       = 0;
    endtask

    task automatic modelEdge();
        logic [LANES-1:0] qa;
        logic [LANES-1:0] th;
        for (int i = 0; i < LANES; i++) begin
            qa[i] = laneRaw(i) && lane_en[i] && !m_inj[i];
            th[i] = laneRaw(i) && m_inj[i];
        end
        e_lock = e_lock || (THRESH != 0 && e_cnt >= THRESH);
        if (qa != 0 && e_cnt < CNT_MAX) e_cnt = e_cnt + 1;
        e_alarm_vec = qa;
        e_alarm     = (qa != 0);
        e_selftest  = (th != 0);
        e_status    = (status_clr ? '0 : e_status) | qa;
        if (load) begin
            for (int i = 0; i < LANES; i++) begin
                m_main[i]   = int'(data[i*WIDTH +: WIDTH]);
                m_shadow[i] = inj_mask[i] ? m_main[i] : (~m_main[i] & LMASK);
                m_inj[i]    = inj_mask[i];
            end
        end
    endtask

    task automatic checkAll(input string phase);
        logic [DW-1:0] eq;
        for (int i = 0; i < LANES; i++) eq[i*WIDTH +: WIDTH] = WIDTH'(m_main[i]);
        checkOutput({phase, ".q"},           q,           eq);
        checkOutput({phase, ".alarm"},       alarm,       e_alarm);
        checkOutput({phase, ".alarm_vec"},   alarm_vec,   e_alarm_vec);
        checkOutput({phase, ".status"},      status,      e_status);
        checkOutput({phase, ".fault_cnt"},   fault_cnt,   e_cnt);
        checkOutput({phase, ".lockdown"},    lockdown,    e_lock);
        checkOutput({phase, ".selftest_ok"}, selftest_ok, e_selftest);
    endtask

    task automatic applyStimulus(input string phase, input bit ld, input logic [DW-1:0] d,
                                 input logic [LANES-1:0] en, input logic [LANES-1:0] inj,
                                 input bit clr);
        load       = ld;
        data       = d;
        lane_en    = en;
        inj_mask   = inj;
        status_clr = clr;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(phase);
    endtask

    // Flipping one shadow bit makes that bit pair equal; the force holds it there.
    task automatic injectFault(input int lane, input int b);
        m_shadow[lane] = m_shadow[lane] ^ (1 << b);
        force_val = packShadow();
        force dut.shadow_reg = force_val;
    endtask

    // Re-force to the consistent value first so release leaves a clean register either way.
    task automatic clearFault();
        for (int i = 0; i < LANES; i++) begin
            m_shadow[i] = m_inj[i] ? m_main[i] : (~m_main[i] & LMASK);
        end
        force_val = packShadow();
        force dut.shadow_reg = force_val;
        #0;
        release dut.shadow_reg;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("reset");
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int fault_left;
        bit ld;
        logic [LANES-1:0] inj;

        rst = 1'b1; load = 1'b0; data = '0; lane_en = '0; inj_mask = '0; status_clr = 1'b0;
        modelReset();
        #12;
        checkAll("por");
        rst = 1'b0;

        applyStimulus("clean", 1'b1, 32'hA5C3_0FF0, 4'hF, 4'h0, 1'b0);
        repeat (2) applyStimulus("clean_idle", 1'b0, '0, 4'hF, 4'h0, 1'b0);

        injectFault(2, 3);
        applyStimulus("lane2_fault", 1'b0, '0, 4'hF, 4'h0, 1'b0);
        clearFault();
        repeat (2) applyStimulus("lane2_after", 1'b0, '0, 4'hF, 4'h0, 1'b0);
        applyStimulus("clr", 1'b0, '0, 4'hF, 4'h0, 1'b1);

        injectFault(2, 3);
        applyStimulus("masked_fault", 1'b0, '0, 4'b1011, 4'h0, 1'b0);
        clearFault();
        applyStimulus("masked_after", 1'b0, '0, 4'b1011, 4'h0, 1'b0);

        applyStimulus("inj_load", 1'b1, 32'h0000_0012, 4'hF, 4'b0001, 1'b0);
        applyStimulus("inj_hit", 1'b0, '0, 4'hF, 4'b1111, 1'b0);
        applyStimulus("inj_reload", 1'b1, 32'h0000_0012, 4'hF, 4'h0, 1'b0);
        applyStimulus("inj_gone", 1'b0, '0, 4'hF, 4'h0, 1'b0);

        injectFault(1, 0);
        applyStimulus("clr_race", 1'b0, '0, 4'hF, 4'h0, 1'b1);
        clearFault();
        applyStimulus("clr_alone", 1'b0, '0, 4'hF, 4'h0, 1'b1);

        injectFault(0, 5);
        repeat (6) applyStimulus("persist", 1'b0, '0, 4'hF, 4'h0, 1'b0);
        clearFault();
        repeat (2) applyStimulus("lock_hold", 1'b0, '0, 4'hF, 4'h0, 1'b1);

        doReset();
        fault_left = 0;
        for (int n = 0; n < 400; n++) begin
            if (fault_left == 0 && $urandom_range(0, 9) == 0) begin
                injectFault(int'($urandom_range(0, LANES - 1)), int'($urandom_range(0, WIDTH - 1)));
                fault_left = int'($urandom_range(1, 3));
            end
            ld  = (fault_left == 0) && ($urandom_range(0, 1) == 1);
            inj = ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0;
            applyStimulus("rand", ld, DW'($urandom), LANES'($urandom), inj,
                          ($urandom_range(0, 7) == 0));
            if (fault_left > 0) begin
                fault_left--;
                if (fault_left == 0) clearFault();
            end
        end
        if (fault_left > 0) clearFault();

        doReset();
        applyStimulus("sat_load", 1'b1, 32'h1234_5678, 4'hF, 4'h0, 1'b0);
        injectFault(0, 0);
        repeat (CNT_MAX + 5) applyStimulus("sat", 1'b0, '0, 4'hF, 4'h0, 1'b0);
        clearFault();
        applyStimulus("sat_end", 1'b0, '0, 4'hF, 4'h0, 1'b0);

        injectFault(3, 7);
        applyStimulus("pre_rst", 1'b0, '0, 4'hF, 4'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("mid_rst");
        clearFault();
        #1;
        rst = 1'b0;
        applyStimulus("post_rst", 1'b0, '0, 4'hF, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
